// File: rtl/div_sequencer.sv
// div_sequencer
//   Control stage between the execute stage and the 33-cycle iterative
//   divider. Accepts one LoongArch div.w / mod.w / div.wu / mod.wu request
//   at a time, holds the operands and signedness steady while the divider
//   runs, captures the quotient or remainder and hands one 32-bit result
//   downstream. A divide by zero is answered directly without starting the
//   divider. flush cancels whatever is held or in flight.
//
// Ports
//   div_clk, reset        clock, synchronous active-high reset
//   flush                 cancel any held or in-flight request
//   req_valid/req_ready   upstream handshake
//   req_op                00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
//   req_x, req_y          dividend, divisor
//   rsp_valid/rsp_ready   downstream handshake
//   rsp_data              quotient or remainder
//   div_req               registered divider start/hold level
//   div_signed            signed divide select (~op[1] of the held request)
//   div_x, div_y          held operands for the divider
//   div_complete          one-cycle completion pulse from the divider
//   div_s, div_r          divider quotient / remainder, valid the cycle
//                         after div_complete
module div_sequencer (
  input  logic        div_clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        div_req,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic        div_complete,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r
);

  typedef enum logic [1:0] {IDLE, BUSY, CAPT, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [1:0]  op_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic        accept;
  logic        zero_div;

  assign accept   = (state == IDLE) && req_valid && !flush;
  assign zero_div = (req_y == 32'd0);

  // State register
  always_ff @(posedge div_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (req_valid) next_state = zero_div ? DONE : BUSY;
        BUSY: if (div_complete) next_state = CAPT;
        CAPT: next_state = DONE;
        DONE: if (rsp_ready) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from the state
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == DONE);
  end

  // Held request, divider start level and result register.
  // div_req follows "next state is BUSY", so it drops on completion or
  // flush and is always low for at least one cycle between two divides.
  always_ff @(posedge div_clk) begin
    if (reset) begin
      op_q     <= 2'b00;
      x_q      <= 32'd0;
      y_q      <= 32'd0;
      rsp_data <= 32'd0;
      div_req  <= 1'b0;
    end else begin
      div_req <= (next_state == BUSY);
      if (accept) begin
        op_q <= req_op;
        x_q  <= req_x;
        y_q  <= req_y;
        // Divide-by-zero fast path: quotient all ones, remainder = dividend
        if (zero_div) begin
          rsp_data <= req_op[0] ? req_x : 32'hFFFF_FFFF;
        end
      end else if ((state == CAPT) && !flush) begin
        rsp_data <= op_q[0] ? div_r : div_s;
      end
    end
  end

  assign div_signed = ~op_q[1];
  assign div_x      = x_q;
  assign div_y      = y_q;

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Control stage between the execute stage and the 33-cycle iterative divider. It accepts one LoongArch divide/modulo request at a time through a valid/ready handshake and holds operands and `div_signed` stable for the whole computation. It drives the divider's level-sensitive start input, captures quotient or remainder when the divider finishes, and presents one 32-bit result downstream through a second valid/ready handshake. Flush support lets the pipeline cancel an in-flight divide on exceptions or branch mispredicts.

## Interface
- No parameters.
- `div_clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  cancels any request held or in flight.
- `req_valid`  in  1  upstream request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  2  00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu.
- `req_x`  in  32  dividend.
- `req_y`  in  32  divisor.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  downstream takes the result.
- `rsp_data`  out  32  quotient or remainder.
- `div_req`  out  1  divider start/hold level; registered.
- `div_signed`  out  1  equals `~op[1]` of the held request.
- `div_x`, `div_y`  out  32  held operands.
- `div_complete`  in  1  one-cycle divider completion pulse.
- `div_s`, `div_r`  in  32  divider quotient and remainder. Both are valid in the cycle after `div_complete`.

## Operation
- Four states: IDLE, BUSY, CAPT, DONE.
- Reset values: state IDLE, `div_req`=0, `rsp_valid`=0, `rsp_data`=0, held op/x/y=0.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` with no flush: latch op/x/y.
  - If `req_y`==0: go to DONE with a fast-path result. Quotient ops return 0xFFFFFFFF. Modulo ops return `req_x`. The divider is not started.
  - Otherwise go to BUSY and set `div_req`<=1.
- BUSY:
  - `req_ready`=0; `div_req` is held at 1.
  - On `div_complete`: set `div_req`<=0 and go to CAPT.
- CAPT:
  - `rsp_data` <= `div_s` when op[0]==0, otherwise `div_r`.
  - Go to DONE.
- DONE:
  - `rsp_valid`=1; `rsp_data` stays stable until the handshake completes.
  - On `rsp_ready`: go to IDLE.
  - A new request is not accepted in the same cycle; `req_ready` is 0 in DONE.
- `div_x`, `div_y` and `div_signed` come from the held registers. They stay constant from acceptance until the block returns to IDLE, because the divider samples them every cycle.
- Flush:
  - Has highest priority in every state. Next state is IDLE, `div_req`<=0 and `rsp_valid`<=0.
  - A request presented in the same IDLE cycle as the flush is not accepted.
  - A flush in BUSY or CAPT aborts the divider. `div_req` is low for at least one cycle, which resets the divider's counter before any new start.
- `div_req` must be low for at least one cycle between any two divides; the state sequence guarantees this.
- Signed overflow (0x80000000 / 0xFFFFFFFF, div.w) is not special-cased: the result is 0x80000000, and mod.w gives 0.

## Timing
- Let the acceptance edge close cycle A.
- Cycle A+1: BUSY, `div_req`=1.
- Divider iterates in cycles A+1..A+33; `div_complete` is high in cycle A+34.
- Cycle A+35: CAPT, `div_req`=0.
- Cycle A+36: `rsp_valid`=1.
- Zero-divisor path: `rsp_valid`=1 in cycle A+1.
- Throughput: at best one divide every 37 cycles; the next request is accepted in the first IDLE cycle after the response handshake.
- A `div_complete` seen outside BUSY is ignored.
- `rsp_valid` never drops without `rsp_ready` or flush.

## Test plan
- div.w x=0xFFFFFFF9 (−7), y=2 → `rsp_data`=0xFFFFFFFD, `rsp_valid` first high at A+36. Same operands with mod.w → 0xFFFFFFFF.
- div.wu x=0xFFFFFFFF, y=3 → 0x55555555. mod.wu x=100, y=7 → 2. `div_signed`=0 throughout both.
- div.w and mod.w with y=0, x=0x12345678 → 0xFFFFFFFF and 0x12345678 respectively, `rsp_valid` at A+1, `div_req` never asserted.
- Flush in cycle A+20 of a divide → `div_req` low in A+21 and no response. A new div.w 20/4 accepted in A+21 → 5 at A+21+36.
- Backpressure: `rsp_ready`=0 for 10 cycles after `rsp_valid` → `rsp_data` stable, `req_ready`=0. Raising `rsp_ready` → IDLE the next cycle, `req_ready`=1.
- Reset asserted mid-BUSY → next cycle all outputs at reset values and `div_req`=0. div.w 0x80000000 / 0xFFFFFFFF → 0x80000000.
